// File: rtl/mem_burst_pkg.sv
// Shared types and byte-lane helpers for the memory burst sequencer.
package mem_burst_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int BEAT_W     = BYTE_W * WORD_BYTES;
    localparam int LANE_W     = $clog2(WORD_BYTES);
    localparam int BYTE_IDX_W = $clog2(WORD_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_BYTES,
        RD_BYTES,
        RD_HOLD
    } state_e;

    function automatic logic [BYTE_W-1:0] lane_sel(
        input logic [BEAT_W-1:0] beat,
        input logic [LANE_W-1:0] k
    );
        return beat[k*BYTE_W +: BYTE_W];
    endfunction

    function automatic logic [BEAT_W-1:0] lane_ins(
        input logic [BEAT_W-1:0] beat,
        input logic [LANE_W-1:0] k,
        input logic [BYTE_W-1:0] b
    );
        logic [BEAT_W-1:0] r;
        r = beat;
        r[k*BYTE_W +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_burst_ctrl_serdes.sv
// Beat register plus byte index: splits a write beat into bytes
// and rebuilds a read beat from bytes returned one cycle late.
module beat_byte_serdes
    import mem_burst_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [BEAT_W-1:0]     wdata_i,
    input  logic                  clr_i,
    input  logic                  adv_i,
    input  logic                  cap_i,
    input  logic [BYTE_W-1:0]     rbyte_i,
    output logic [BYTE_IDX_W-1:0] idx_o,
    output logic [BYTE_W-1:0]     wbyte_o,
    output logic [BEAT_W-1:0]     beat_o
);

    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [LANE_W-1:0]     cap_lane;

    always_comb begin
        idx_d    = idx_q;
        beat_d   = beat_q;
        // read data lags the request by one cycle, so it lands in lane idx-1
        cap_lane = LANE_W'(idx_q - BYTE_IDX_W'(1));
        if (load_i || clr_i) begin
            idx_d = '0;
        end else if (adv_i) begin
            idx_d = idx_q + BYTE_IDX_W'(1);
        end
        if (load_i) begin
            beat_d = wdata_i;
        end else if (cap_i) begin
            beat_d = lane_ins(beat_q, cap_lane, rbyte_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            beat_q <= '0;
        end else begin
            idx_q  <= idx_d;
            beat_q <= beat_d;
        end
    end

    assign idx_o   = idx_q;
    assign wbyte_o = lane_sel(beat_q, idx_q[LANE_W-1:0]);
    assign beat_o  = beat_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Word-burst sequencer serialising 32-bit beats onto a byte-wide
// memory with separate write and read ports.
module mem_burst_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_BYTES = 4,
    parameter int LEN_WIDTH  = 8,
    localparam int BW        = DATA_WIDTH * WORD_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [BW-1:0]         wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [BW-1:0]         rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    import mem_burst_pkg::*;

    localparam int OFF_W = $clog2(WORD_BYTES);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

    logic                  ser_load, ser_clr, ser_adv, ser_cap;
    logic [BYTE_IDX_W-1:0] idx;
    logic [BYTE_W-1:0]     wbyte;
    logic [BEAT_W-1:0]     beat;
    logic                  is_last;
    logic                  idx_top;
    logic [ADDR_WIDTH-1:0] byte_addr;

    beat_byte_serdes u_serdes (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ser_load),
        .wdata_i (wr_data),
        .clr_i   (ser_clr),
        .adv_i   (ser_adv),
        .cap_i   (ser_cap),
        .rbyte_i (mem_data_out),
        .idx_o   (idx),
        .wbyte_o (wbyte),
        .beat_o  (beat)
    );

    assign byte_addr = addr_q + ADDR_WIDTH'(idx);
    assign is_last   = (beat_cnt_q == len_q);
    assign idx_top   = (idx == BYTE_IDX_W'(WORD_BYTES));

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        len_d             = len_q;
        beat_cnt_d        = beat_cnt_q;
        cmd_ready         = 1'b0;
        wr_ready          = 1'b0;
        rd_valid          = 1'b0;
        rd_last           = 1'b0;
        rd_data           = '0;
        done              = 1'b0;
        ser_load          = 1'b0;
        ser_clr           = 1'b0;
        ser_adv           = 1'b0;
        ser_cap           = 1'b0;
        mem_write_en      = 1'b0;
        mem_write_address = '0;
        mem_data_in       = '0;
        mem_read_en       = 1'b0;
        mem_read_address  = '0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d     = {cmd_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                    len_d      = cmd_len;
                    beat_cnt_d = '0;
                    if (cmd_write) begin
                        state_d = WR_WAIT;
                    end else begin
                        ser_clr = 1'b1;
                        state_d = RD_BYTES;
                    end
                end
            end
            WR_WAIT: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    ser_load = 1'b1;
                    state_d  = WR_BYTES;
                end
            end
            WR_BYTES: begin
                mem_write_en      = 1'b1;
                mem_write_address = byte_addr;
                mem_data_in       = wbyte;
                ser_adv           = 1'b1;
                if (idx == BYTE_IDX_W'(WORD_BYTES - 1)) begin
                    addr_d = addr_q + ADDR_WIDTH'(WORD_BYTES);
                    if (is_last) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                        state_d    = WR_WAIT;
                    end
                end
            end
            RD_BYTES: begin
                mem_read_en      = !idx_top;
                mem_read_address = idx_top ? '0 : byte_addr;
                ser_adv          = !idx_top;
                ser_cap          = (idx != '0);
                if (idx_top) begin
                    addr_d  = addr_q + ADDR_WIDTH'(WORD_BYTES);
                    state_d = RD_HOLD;
                end
            end
            RD_HOLD: begin
                rd_valid = 1'b1;
                rd_last  = is_last;
                rd_data  = beat;
                if (rd_ready) begin
                    if (is_last) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                        ser_clr    = 1'b1;
                        state_d    = RD_BYTES;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench: byte memory model behind mem_burst_ctrl,
// hand-computed beats and byte placements.
module tb_mem_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic        mem_write_en, mem_read_en;
    logic [9:0]  mem_write_address, mem_read_address;
    logic [7:0]  mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    mem_burst_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_data           (rd_data),
        .rd_last           (rd_last),
        .done              (done),
        .mem_write_en      (mem_write_en),
        .mem_write_address (mem_write_address),
        .mem_data_in       (mem_data_in),
        .mem_read_en       (mem_read_en),
        .mem_read_address  (mem_read_address),
        .mem_data_out      (mem_data_out)
    );

    typedef struct {
        int         cyc;
        logic [9:0] a;
        logic [7:0] d;
    } wlog_t;

    logic [7:0]  mem [1024];
    bit          mem_init = 1'b0;
    wlog_t       wlog[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          rden_cnt = 0;
    logic        both_seen = 1'b0;
    logic [31:0] rq_d[$];
    logic        rq_l[$];
    int          checks = 0;
    int          errors = 0;

    logic [6:0]  ctl;
    logic [27:0] bus;
    assign ctl = {cmd_ready, wr_ready, rd_valid, rd_last,
                  done, mem_write_en, mem_read_en};
    assign bus = {mem_write_address, mem_data_in, mem_read_address};

    // byte memory: registered read, data valid the cycle after read_en
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
            mem_init = 1'b1;
        end
        if (mem_read_en) mem_data_out <= mem[mem_read_address];
        if (mem_write_en) begin
            mem[mem_write_address] = mem_data_in;
            wlog.push_back('{cyc, mem_write_address, mem_data_in});
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_read_en) rden_cnt <= rden_cnt + 1;
        if (mem_write_en && mem_read_en) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 60 && !cmd_ready; n++) @(negedge clk);
        if (!cmd_ready) chk("idle_timeout", 64'(cmd_ready), 64'(1));
    endtask

    task automatic send_cmd(input logic w, input logic [9:0] a,
                            input logic [7:0] len);
        int n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = len;
        for (n = 0; n < 60 && !cmd_ready; n++) @(negedge clk);
        if (!cmd_ready) chk("cmd_timeout", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        int n;
        wr_valid = 1'b1;
        wr_data  = d;
        for (n = 0; n < 60 && !wr_ready; n++) @(negedge clk);
        if (!wr_ready) chk("wr_timeout", 64'(wr_ready), 64'(1));
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [9:0] a, input logic [7:0] len,
                               input logic [31:0] b0, input logic [31:0] b1);
        send_cmd(1'b1, a, len);
        send_beat(b0);
        if (len != 0) send_beat(b1);
        wait_idle();
    endtask

    task automatic read_burst(input logic [9:0] a, input logic [7:0] len,
                              input int hold);
        logic [31:0] snap;
        int n;
        rq_d.delete();
        rq_l.delete();
        send_cmd(1'b0, a, len);
        for (int b = 0; b <= int'(len); b++) begin
            for (n = 0; n < 60 && !rd_valid; n++) @(negedge clk);
            if (!rd_valid) chk("rd_timeout", 64'(rd_valid), 64'(1));
            snap = rd_data;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", 64'(rd_valid), 64'(1));
                chk("hold_data", 64'(rd_data), 64'(snap));
            end
            rd_ready = 1'b1;
            rq_d.push_back(rd_data);
            rq_l.push_back(rd_last);
            @(negedge clk);
            rd_ready = 1'b0;
        end
        wait_idle();
    endtask

    task automatic chk_wr(input string tag, input int base,
                          input logic [9:0] a, input logic [31:0] beat);
        for (int k = 0; k < 4; k++) begin
            if (base + k < wlog.size()) begin
                chk({tag, "_addr"}, 64'(wlog[base+k].a), 64'(a + 10'(k)));
                chk({tag, "_data"}, 64'(wlog[base+k].d), 64'(beat[8*k +: 8]));
                chk({tag, "_cyc"}, 64'(wlog[base+k].cyc - wlog[base].cyc),
                    64'(k));
            end else begin
                chk({tag, "_count"}, 64'(wlog.size()), 64'(base + 4));
            end
        end
    endtask

    task automatic chk_rd(input string tag, input int i,
                          input logic [31:0] d, input logic l);
        if (i < rq_d.size()) begin
            chk({tag, "_data"}, 64'(rq_d[i]), 64'(d));
            chk({tag, "_last"}, 64'(rq_l[i]), 64'(l));
        end else begin
            chk({tag, "_count"}, 64'(rq_d.size()), 64'(i + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int d0, r0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'(ctl), 64'(7'b1000000));
        chk("rst_bus", 64'(bus), 64'(0));
        chk("rst_rdata", 64'(rd_data), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ctl", 64'(ctl), 64'(7'b1000000));

        // 1: single-beat write at 0
        wlog.delete();
        d0 = done_cnt;
        write_burst(10'd0, 8'd0, 32'hDEADBEEF, 32'h0);
        chk("t1_nwr", 64'(wlog.size()), 64'(4));
        chk_wr("t1", 0, 10'd0, 32'hDEADBEEF);
        chk("t1_done", 64'(done_cnt - d0), 64'(1));

        // 2: single-beat read back
        d0 = done_cnt;
        read_burst(10'd0, 8'd0, 0);
        chk_rd("t2", 0, 32'hDEADBEEF, 1'b1);
        chk("t2_done", 64'(done_cnt - d0), 64'(1));

        // 3: two-beat write at 4 and read back
        wlog.delete();
        d0 = done_cnt;
        write_burst(10'd4, 8'd1, 32'h12345678, 32'hCAFEF00D);
        chk("t3_nwr", 64'(wlog.size()), 64'(8));
        chk_wr("t3b0", 0, 10'd4, 32'h12345678);
        chk_wr("t3b1", 4, 10'd8, 32'hCAFEF00D);
        chk("t3_wdone", 64'(done_cnt - d0), 64'(1));
        read_burst(10'd4, 8'd1, 0);
        chk_rd("t3r0", 0, 32'h12345678, 1'b0);
        chk_rd("t3r1", 1, 32'hCAFEF00D, 1'b1);

        // 4: burst wrapping from 1023 to 0
        wlog.delete();
        write_burst(10'd1020, 8'd1, 32'h11223344, 32'h55667788);
        chk_wr("t4b0", 0, 10'd1020, 32'h11223344);
        chk_wr("t4b1", 4, 10'd0, 32'h55667788);
        read_burst(10'd1020, 8'd1, 0);
        chk_rd("t4r0", 0, 32'h11223344, 1'b0);
        chk_rd("t4r1", 1, 32'h55667788, 1'b1);

        // 5: unaligned start, stalled consumer
        r0 = rden_cnt;
        d0 = done_cnt;
        read_burst(10'h006, 8'd2, 3);
        chk_rd("t5r0", 0, 32'h12345678, 1'b0);
        chk_rd("t5r1", 1, 32'hCAFEF00D, 1'b0);
        chk_rd("t5r2", 2, 32'hAAABA8A9, 1'b1);
        chk("t5_rden", 64'(rden_cnt - r0), 64'(12));
        chk("t5_done", 64'(done_cnt - d0), 64'(1));

        // 6: reset after two bytes of a write beat
        send_cmd(1'b1, 10'h040, 8'd0);
        send_beat(32'hA1B2C3D4);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_ctl", 64'(ctl), 64'(7'b1000000));
        chk("t6_rst_bus", 64'(bus), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_ctl", 64'(ctl), 64'(7'b1000000));
        chk("t6_mem", 64'({mem[10'h043], mem[10'h042], mem[10'h041], mem[10'h040]}),
            64'(32'hE6E7C3D4));
        read_burst(10'h040, 8'd0, 0);
        chk_rd("t6r0", 0, 32'hE6E7C3D4, 1'b1);

        chk("rw_exclusive", 64'(both_seen), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
